vga_sync: RTL and testbench

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock. It divides the clock to a 25 MHz pixel enable and runs horizontal and vertical pixel counters. It produces the `x`, `y` and `video_on` signals consumed by the pixel generator, plus the registered `hsync`/`vsync` outputs for the VGA connector. It also provides a one-clock `p_tick` pixel strobe and a one-clock `frame_tick` so downstream logic can update once per pixel or once per frame.

---
 rtl/vga_sync.sv | 105 ++++++++++
 tb/tb_vga_sync.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// ---------------------------------------------------------------------------
// vga_sync
//   VGA timing generator (default 640x480 @ 60 Hz from a 100 MHz clock).
//   A free-running 2-bit divider produces a one-clk pixel strobe every
//   4 clocks. Horizontal and vertical counters advance on that strobe.
//   The sync outputs are registered from the counters' next-state values, so
//   they line up exactly with the x/y values they describe.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   hsync      out  horizontal sync, active-low, registered
//   vsync      out  vertical sync, active-low, registered
//   video_on   out  current (x,y) is inside the visible area
//   p_tick     out  pixel strobe, one clk wide, every 4th clk
//   frame_tick out  one-clk pulse in the cycle before (x,y) wraps to (0,0)
//   x          out  horizontal pixel count, 0..H_TOTAL-1
//   y          out  vertical line count, 0..V_TOTAL-1
// ---------------------------------------------------------------------------
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       frame_tick,
    output logic [9:0] x,
    output logic [9:0] y
);

    localparam int H_TOTAL_I = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL_I = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL_I - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL_I - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [1:0] r_div;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hsync;
    logic       r_vsync;

    logic       w_p_tick;
    logic       w_x_end;
    logic       w_y_end;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;

    assign w_p_tick = (r_div == 2'd3);
    assign w_x_end  = (r_x == H_MAX);
    assign w_y_end  = (r_y == V_MAX);

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_p_tick) begin
            w_x_next = w_x_end ? 10'd0 : r_x + 10'd1;
            // y only moves on the last pixel of a line
            if (w_x_end)
                w_y_next = w_y_end ? 10'd0 : r_y + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div   <= 2'd0;
            r_x     <= 10'd0;
            r_y     <= 10'd0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_div   <= r_div + 2'd1;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            // Decoding next-state counters keeps syncs aligned with x/y
            r_hsync <= !((w_x_next >= HS_START) && (w_x_next <= HS_END));
            r_vsync <= !((w_y_next >= VS_START) && (w_y_next <= VS_END));
        end
    end

    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign x          = r_x;
    assign y          = r_y;
    assign p_tick     = w_p_tick;
    assign video_on   = (r_x < H_VIS) && (r_y < V_VIS);
    assign frame_tick = w_p_tick && w_x_end && w_y_end;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench. Full-size instance covers reset, pixel strobe, line timing
// and asynchronous mid-line reset. A reduced-geometry instance (16x10 total)
// covers vertical sync, frame wrap and frame_tick spacing in a short run.
module tb_vga_sync;

    logic       clk;
    logic       reset;
    logic       rst_s;

    logic       hsync, vsync, video_on, p_tick, frame_tick;
    logic [9:0] x, y;

    logic       s_hsync, s_vsync, s_video_on, s_p_tick, s_frame_tick;
    logic [9:0] s_x, s_y;

    int checks;
    int errors;

    vga_sync u_dut (
        .clk        (clk),
        .reset      (reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .p_tick     (p_tick),
        .frame_tick (frame_tick),
        .x          (x),
        .y          (y)
    );

    // H: 8+2+3+3 = 16 (hsync low x=10..12); V: 6+1+2+1 = 10 (vsync low y=7..8)
    // line = 64 clk, frame = 640 clk
    vga_sync #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_small (
        .clk        (clk),
        .reset      (rst_s),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .video_on   (s_video_on),
        .p_tick     (s_p_tick),
        .frame_tick (s_frame_tick),
        .x          (s_x),
        .y          (s_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int n_ft;
    int ft_edge[2];
    int vs_low;
    int vo_bad;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        rst_s  = 1'b0;

        // ---------------- reset state
        step(10);
        chk("rst_x",        32'(x), 0);
        chk("rst_y",        32'(y), 0);
        chk("rst_hsync",    32'(hsync), 1);
        chk("rst_vsync",    32'(vsync), 1);
        chk("rst_p_tick",   32'(p_tick), 0);
        chk("rst_frame",    32'(frame_tick), 0);
        chk("rst_video_on", 32'(video_on), 1);
        chk("rst_s_x",      32'(s_x), 0);

        // ---------------- pixel strobe after release
        reset = 1'b1;
        step(2);
        chk("e2_p_tick",    32'(p_tick), 0);
        step(1);                                   // edge 3
        chk("e3_p_tick",    32'(p_tick), 1);
        chk("e3_x",         32'(x), 0);
        step(1);                                   // edge 4
        chk("e4_x",         32'(x), 1);
        chk("e4_p_tick",    32'(p_tick), 0);
        step(3);                                   // edge 7
        chk("e7_p_tick",    32'(p_tick), 1);
        step(1);                                   // edge 8
        chk("e8_x",         32'(x), 2);

        // ---------------- line timing (x = k after edge 4k)
        step(2551);                                // edge 2559
        chk("x639",         32'(x), 639);
        chk("vo_639",       32'(video_on), 1);
        step(1);                                   // edge 2560
        chk("x640",         32'(x), 640);
        chk("vo_640",       32'(video_on), 0);
        step(63);                                  // edge 2623
        chk("x655",         32'(x), 655);
        chk("hs_655",       32'(hsync), 1);
        step(1);                                   // edge 2624
        chk("x656",         32'(x), 656);
        chk("hs_656",       32'(hsync), 0);
        step(383);                                 // edge 3007
        chk("x751",         32'(x), 751);
        chk("hs_751",       32'(hsync), 0);
        step(1);                                   // edge 3008
        chk("x752",         32'(x), 752);
        chk("hs_752",       32'(hsync), 1);
        step(191);                                 // edge 3199
        chk("x799",         32'(x), 799);
        chk("y0_eol",       32'(y), 0);
        chk("p_tick_eol",   32'(p_tick), 1);
        chk("ft_eol",       32'(frame_tick), 0);
        step(1);                                   // edge 3200
        chk("wrap_x",       32'(x), 0);
        chk("wrap_y",       32'(y), 1);
        chk("vs_y1",        32'(vsync), 1);

        // ---------------- async reset mid-line
        step(1200);                                // edge 4400
        chk("pre_rst_x",    32'(x), 300);
        chk("pre_rst_y",    32'(y), 1);
        #2 reset = 1'b0;
        #1;                                        // still before next posedge
        chk("arst_x",       32'(x), 0);
        chk("arst_y",       32'(y), 0);
        chk("arst_p_tick",  32'(p_tick), 0);
        chk("arst_hsync",   32'(hsync), 1);
        chk("arst_vo",      32'(video_on), 1);
        step(2);
        reset = 1'b1;
        step(3);
        chk("rel_p_tick",   32'(p_tick), 1);
        chk("rel_x3",       32'(x), 0);
        step(1);
        chk("rel_x4",       32'(x), 1);

        // ---------------- reduced geometry: vsync and frame wrap
        rst_s = 1'b1;
        step(447);                                 // k=111 -> (15,6)
        chk("s_y6",         32'(s_y), 6);
        chk("s_vs_y6",      32'(s_vsync), 1);
        chk("s_vo_y6",      32'(s_video_on), 0);
        step(1);                                   // k=112 -> (0,7)
        chk("s_y7",         32'(s_y), 7);
        chk("s_vs_y7",      32'(s_vsync), 0);
        step(127);                                 // edge 575 -> (15,8)
        chk("s_vs_y8",      32'(s_vsync), 0);
        step(1);                                   // edge 576 -> (0,9)
        chk("s_y9",         32'(s_y), 9);
        chk("s_vs_y9",      32'(s_vsync), 1);
        step(63);                                  // edge 639 -> (15,9)
        chk("s_x15",        32'(s_x), 15);
        chk("s_ft",         32'(s_frame_tick), 1);
        step(1);                                   // edge 640 -> (0,0)
        chk("s_wrap_x",     32'(s_x), 0);
        chk("s_wrap_y",     32'(s_y), 0);
        chk("s_ft_off",     32'(s_frame_tick), 0);

        // two more frames: edges 641..1930
        n_ft   = 0;
        vs_low = 0;
        vo_bad = 0;
        for (int e = 641; e <= 1930; e++) begin
            step(1);
            if (s_frame_tick) begin
                if (n_ft < 2) ft_edge[n_ft] = e;
                n_ft++;
            end
            if (!s_vsync) vs_low++;
            if (s_video_on && s_y >= 10'd6) vo_bad++;
        end
        chk("s_ft_count",   32'(n_ft), 2);
        chk("s_ft_edge1",   32'(ft_edge[0]), 1279);
        chk("s_ft_edge2",   32'(ft_edge[1]), 1919);
        chk("s_vs_low",     32'(vs_low), 256);
        chk("s_vo_bad",     32'(vo_bad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
